bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Avalon-MM-style bus initiator between the CPU datapath and the memory bus. It is the master end of the interface that bus_memory-class slaves implement.
- Accepts single load/store requests (byte/half/word, signed or unsigned) from the CPU and steers data onto byte lanes.
- Drives address/read/write/byteenable/writedata, honours waitrequest, and returns aligned, extended load data with a one-cycle response pulse.

Parameters:
- TIMEOUT_CYCLES, 0, max consecutive waitrequest-high cycles before abort with error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req_valid  in  1  request present; sampled only when cpu_req_ready=1
- cpu_req_ready  out  1  block idle, can accept a request
- cpu_req_write  in  1  1=store, 0=load
- cpu_req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
- cpu_req_signed  in  1  sign-extend load result
- cpu_req_addr  in  32  byte address
- cpu_req_wdata  in  32  store data, right-justified
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_resp_rdata  out  32  load result, extended; 0 for stores and errors
- cpu_resp_err  out  1  misaligned access or timeout; qualified by cpu_resp_valid
- address  out  32  word-aligned bus address, {addr[31:2],2'b00}
- write  out  1  bus write strobe
- read  out  1  bus read strobe
- waitrequest  in  1  slave stall
- writedata  out  32  lane-steered store data
- byteenable  out  4  active lanes
- readdata  in  32  valid in the cycle after a read is accepted

Behaviour:
- Reset, asynchronous: state=IDLE. read, write, cpu_resp_valid and cpu_resp_err=0. address, writedata and cpu_resp_rdata=0. byteenable=0. The timeout counter is cleared.
- Reset mid-transaction drops read/write immediately; no response is issued.
- All outputs are registered. cpu_req_ready=1 only in IDLE.
- Offset o=addr[1:0].
  - Byte: byteenable=1<<o; writedata={4{wdata[7:0]}}.
  - Half: o=0 gives 0011, o=2 gives 1100; writedata={2{wdata[15:0]}}.
  - Word: o=0 gives 1111, writedata=wdata.
- Misaligned = half with o odd, word with o!=0, or size=3.
- States:
  - IDLE: on cpu_req_valid, latch the request.
    - If misaligned, go to RESP with err=1; the bus is never touched.
    - Otherwise go to ACCESS, asserting read or write with address/byteenable/writedata in the next cycle.
  - ACCESS: hold all bus outputs stable while waitrequest=1.
    - When waitrequest=0 at a clock edge, the transfer is accepted: deassert read/write.
    - A write goes to RESP; a read goes to RDATA.
    - Timeout: if TIMEOUT_CYCLES>0 and waitrequest has been high for TIMEOUT_CYCLES consecutive ACCESS cycles, deassert the strobe and go to RESP with err=1.
  - RDATA: capture readdata shifted right by 8*o.
    - Byte: extend bit 7. Half: extend bit 15. Extension is zero or sign per cpu_req_signed.
    - Go to RESP.
  - RESP: cpu_resp_valid=1 for exactly one cycle, then IDLE. rdata/err hold until the next response.
- Latency with zero wait states:
  - Load: request at cycle N, read=1 at N+1, resp_valid at N+3.
  - Store: write=1 at N+1, resp_valid at N+2.
  - Misaligned: resp_valid at N+1.
  - Each waitrequest cycle adds one.
- read and write are never asserted together. Exactly one strobe per request. No back-to-back requests without passing through IDLE.
- cpu_req_valid outside IDLE is ignored. The CPU must hold the request until ready.

Decomposition:
- bus_master_pkg: access-size enum (SZ_BYTE/SZ_HALF/SZ_WORD), state enum (IDLE/ACCESS/RDATA/RESP), byteenable constants.
- Sub-module bus_lane_align, combinational:
  - Store direction: size, offset, wdata → byteenable, writedata.
  - Load direction: size, offset, signed, readdata → extended rdata.

Test Plan:
- Word load, addr 0x104, readdata 0xDEADBEEF, waitrequest=0 → read=1 one cycle, address=0x104, byteenable=1111, resp_valid at N+3, rdata=0xDEADBEEF, err=0.
- Signed byte load, addr 0x103, readdata 0x80xxxxxx → byteenable=1000, rdata=0xFFFFFF80. Unsigned → 0x00000080.
- Half store, addr 0x206, wdata 0x0000ABCD → write=1, address=0x204, byteenable=1100, writedata=0xABCDABCD, resp_valid at N+2.
- Word load with waitrequest high 3 cycles → read and address held stable 4 cycles, resp_valid at N+6, exactly one read acceptance.
- Word load at 0x102 → no read/write ever asserted, resp_valid at N+1, err=1, rdata=0. TIMEOUT_CYCLES=4 with waitrequest stuck high → strobe drops after 4 cycles, err=1.
- reset asserted mid-ACCESS → read=0 asynchronously, no resp_valid, cpu_req_ready=1 after release.

Source files
------------

// File: rtl/bus_master_pkg.sv
// Shared types and constants for the bus master port and its lane aligner.
package bus_master_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'd0);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bus_master_port_lane_align.sv
// Combinational byte-lane steering: store data onto lanes, load data off lanes with extension.
module bus_lane_align
  import bus_master_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_byteenable,
  output logic [31:0] st_writedata,
  input  size_e       ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_signed,
  input  logic [31:0] ld_readdata,
  output logic [31:0] ld_rdata
);

  logic [31:0] w_shift;

  always_comb begin
    st_byteenable = BE_NONE;
    st_writedata  = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_byteenable = BE_BYTE0 << st_off;
        st_writedata  = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_byteenable = st_off[1] ? BE_HI_HALF : BE_LO_HALF;
        st_writedata  = {2{st_wdata[15:0]}};
      end
      SZ_WORD: st_byteenable = BE_WORD;
      default: st_byteenable = BE_NONE;
    endcase
  end

  assign w_shift = ld_readdata >> {ld_off, 3'b000};

  always_comb begin
    ld_rdata = w_shift;
    case (ld_size)
      SZ_BYTE: ld_rdata = {{24{ld_signed & w_shift[7]}}, w_shift[7:0]};
      SZ_HALF: ld_rdata = {{16{ld_signed & w_shift[15]}}, w_shift[15:0]};
      default: ld_rdata = w_shift;
    endcase
  end

endmodule

// File: rtl/bus_master_port.sv
// Avalon-MM style initiator: one CPU load/store at a time, lane-steered, with optional
// waitrequest timeout. All outputs come straight from registers.
module bus_master_port
  import bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  // CPU side: a request transfers on a clock edge where cpu_req_valid && cpu_req_ready;
  // the CPU holds the request stable until then, and cpu_resp_valid is a 1-cycle pulse.
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_write,
  input  logic [1:0]  cpu_req_size,
  input  logic        cpu_req_signed,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_rdata,
  output logic        cpu_resp_err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output state_e      dbg_state
);

  state_e      r_state, w_state;
  logic        r_ready, w_ready;
  logic        r_read, w_read, r_write, w_write;
  logic [31:0] r_address, w_address, r_writedata, w_writedata;
  logic [3:0]  r_byteenable, w_byteenable;
  logic        r_resp_valid, w_resp_valid, r_resp_err, w_resp_err;
  logic [31:0] r_resp_rdata, w_resp_rdata;
  size_e       r_size, w_size;
  logic [1:0]  r_off, w_off;
  logic        r_signed, w_signed;
  logic [31:0] r_wait_cnt, w_wait_cnt;

  size_e       w_req_size;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wd, w_ld_rdata;

  assign w_req_size = size_e'(cpu_req_size);

  bus_lane_align u_align (
    .st_size       (w_req_size),
    .st_off        (cpu_req_addr[1:0]),
    .st_wdata      (cpu_req_wdata),
    .st_byteenable (w_st_be),
    .st_writedata  (w_st_wd),
    .ld_size       (r_size),
    .ld_off        (r_off),
    .ld_signed     (r_signed),
    .ld_readdata   (readdata),
    .ld_rdata      (w_ld_rdata)
  );

  always_comb begin
    w_state      = r_state;
    w_read       = r_read;
    w_write      = r_write;
    w_address    = r_address;
    w_writedata  = r_writedata;
    w_byteenable = r_byteenable;
    w_resp_valid = 1'b0;
    w_resp_err   = r_resp_err;
    w_resp_rdata = r_resp_rdata;
    w_size       = r_size;
    w_off        = r_off;
    w_signed     = r_signed;
    w_wait_cnt   = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (cpu_req_valid) begin
          w_size     = w_req_size;
          w_off      = cpu_req_addr[1:0];
          w_signed   = cpu_req_signed;
          w_wait_cnt = 32'd0;
          if (is_misaligned(w_req_size, cpu_req_addr[1:0])) begin
            w_state      = RESP;
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
            w_resp_rdata = 32'd0;
          end else begin
            w_state      = ACCESS;
            w_read       = ~cpu_req_write;
            w_write      = cpu_req_write;
            w_address    = {cpu_req_addr[31:2], 2'b00};
            w_byteenable = w_st_be;
            w_writedata  = w_st_wd;
          end
        end
      end
      ACCESS: begin
        if (!waitrequest) begin
          w_read  = 1'b0;
          w_write = 1'b0;
          if (r_write) begin
            w_state      = RESP;
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b0;
            w_resp_rdata = 32'd0;
          end else begin
            w_state = RDATA;
          end
        end else if (TIMEOUT_CYCLES != 0 && (r_wait_cnt + 32'd1) >= TIMEOUT_CYCLES) begin
          // Stalled for the full budget: abandon the transfer.
          w_read       = 1'b0;
          w_write      = 1'b0;
          w_state      = RESP;
          w_resp_valid = 1'b1;
          w_resp_err   = 1'b1;
          w_resp_rdata = 32'd0;
        end else begin
          w_wait_cnt = r_wait_cnt + 32'd1;
        end
      end
      RDATA: begin
        w_state      = RESP;
        w_resp_valid = 1'b1;
        w_resp_err   = 1'b0;
        w_resp_rdata = w_ld_rdata;
      end
      default: w_state = IDLE;
    endcase
    w_ready = (w_state == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= 32'd0;
      r_writedata  <= 32'd0;
      r_byteenable <= BE_NONE;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_size       <= SZ_BYTE;
      r_off        <= 2'd0;
      r_signed     <= 1'b0;
      r_wait_cnt   <= 32'd0;
    end else begin
      r_state      <= w_state;
      r_ready      <= w_ready;
      r_read       <= w_read;
      r_write      <= w_write;
      r_address    <= w_address;
      r_writedata  <= w_writedata;
      r_byteenable <= w_byteenable;
      r_resp_valid <= w_resp_valid;
      r_resp_err   <= w_resp_err;
      r_resp_rdata <= w_resp_rdata;
      r_size       <= w_size;
      r_off        <= w_off;
      r_signed     <= w_signed;
      r_wait_cnt   <= w_wait_cnt;
    end
  end

  assign cpu_req_ready  = r_ready;
  assign cpu_resp_valid = r_resp_valid;
  assign cpu_resp_rdata = r_resp_rdata;
  assign cpu_resp_err   = r_resp_err;
  assign address        = r_address;
  assign write          = r_write;
  assign read           = r_read;
  assign writedata      = r_writedata;
  assign byteenable     = r_byteenable;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: directed plan cases plus randomized requests
// checked against a byte-level reference model.
module tb_bus_master_port;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_req_write = 1'b0;
  logic [1:0]  cpu_req_size = 2'd0;
  logic        cpu_req_signed = 1'b0;
  logic [31:0] cpu_req_addr = 32'd0;
  logic [31:0] cpu_req_wdata = 32'd0;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        cpu_resp_err;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = 32'd0;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];

  bus_master_port #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_size(cpu_req_size),
    .cpu_req_signed(cpu_req_signed), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_err(cpu_resp_err),
    .address(address), .write(write), .read(read),
    .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: lanes, steering and extension from byte arithmetic.
  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] addr);
    int o = int'(addr[1:0]);
    if (sz == 2'd3) return 1'b1;
    return (o % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
    int o = int'(addr[1:0]);
    int n = 1 << sz;
    logic [3:0] be = 4'd0;
    for (int b = 0; b < 4; b++) be[b] = (b >= o) && (b < o + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
    int n = 1 << sz;
    logic [31:0] r = 32'd0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] addr, input logic [31:0] rd);
    longint unsigned lanes = 64'd1 << (8 * (1 << sz));
    longint v = longint'((64'(rd) >> (8 * int'(addr[1:0]))) % lanes);
    if (sg && v >= longint'(lanes / 2)) v = v - longint'(lanes);
    return v[31:0];
  endfunction

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd_bus, input int nwait);
    logic mis, to_exp, acc_prev;
    int strobes, accepts, resp_cyc, exp_cyc, exp_strobes;
    logic [32:0] exp_resp, got_resp;
    mis    = model_mis(sz, addr);
    to_exp = !mis && nwait >= TO;
    exp_cyc     = mis ? 1 : to_exp ? TO + 1 : (wr ? 2 : 3) + nwait;
    exp_strobes = mis ? 0 : to_exp ? TO : nwait + 1;
    exp_q.push_back({mis || to_exp, (mis || to_exp || wr) ? 32'd0 : model_rd(sz, sg, addr, rd_bus)});

    @(negedge clk);
    check("req_ready", 33'(cpu_req_ready), 33'd1);
    cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_size = sz;
    cpu_req_signed = sg; cpu_req_addr = addr; cpu_req_wdata = wd;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_addr  = $urandom;
    cpu_req_wdata = $urandom;
    strobes = 0; accepts = 0; resp_cyc = -1; acc_prev = 1'b0; got_resp = 33'd0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      readdata = acc_prev ? rd_bus : $urandom;
      acc_prev = 1'b0;
      if (read && write) check("both_strobes", 33'd1, 33'd0);
      if (read || write) begin
        strobes++;
        check("bus_addr", 33'(address), {1'b0, addr[31:2], 2'b00});
        check("bus_be", 33'(byteenable), 33'(model_be(sz, addr)));
        check("bus_dir", 33'(write), 33'(wr));
        if (write) check("bus_wdata", 33'(writedata), 33'(model_wd(sz, wd)));
        waitrequest = (strobes <= nwait);
        if (!waitrequest) begin accepts++; acc_prev = read; end
      end else begin
        waitrequest = 1'($urandom_range(0, 1));
      end
      if (cpu_resp_valid) begin
        resp_cyc = cyc;
        got_resp = {cpu_resp_err, cpu_resp_rdata};
        break;
      end
      @(negedge clk);
    end
    check("resp_cycle", 33'(resp_cyc), 33'(exp_cyc));
    check("strobe_cycles", 33'(strobes), 33'(exp_strobes));
    check("accepts", 33'(accepts), 33'((mis || to_exp) ? 0 : 1));
    if (exp_q.size() > 0) check("resp_data", got_resp, exp_q.pop_front());
    @(negedge clk);
    check("resp_pulse", 33'(cpu_resp_valid), 33'd0);
    check("resp_hold", {cpu_resp_err, cpu_resp_rdata}, got_resp);
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_size = 2'd2;
    cpu_req_signed = 1'b0; cpu_req_addr = 32'h40;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    waitrequest = 1'b1;
    @(negedge clk);
    check("rst_pre_read", 33'(read), 33'd1);
    #2 reset = 1'b1;
    #1 check("rst_async_read", 33'(read), 33'd0);
    check("rst_async_ready", 33'(cpu_req_ready), 33'd1);
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_resp", 33'(cpu_resp_valid), 33'd0);
    end
    check("rst_ready_after", 33'(cpu_req_ready), 33'd1);
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    int nw;
    repeat (2) @(negedge clk);
    check("rst_ready", 33'(cpu_req_ready), 33'd1);
    check("rst_strobes", 33'({read, write}), 33'd0);
    check("rst_addr", 33'(address), 33'd0);
    check("rst_be", 33'(byteenable), 33'd0);
    check("rst_wdata", 33'(writedata), 33'd0);
    check("rst_resp", {cpu_resp_valid, cpu_resp_err, cpu_resp_rdata[30:0]}, 33'd0);
    reset = 1'b0;

    run_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 0);
    run_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 0);
    run_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 0);
    run_req(1'b1, 2'd1, 1'b0, 32'h206, 32'h0000ABCD, 32'h0, 0);
    run_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h13579BDF, 3);
    run_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h11111111, 0);
    run_req(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h22222222, 100);
    run_req(1'b0, 2'd1, 1'b1, 32'h602, 32'h0, 32'h8001_7FFF, 1);
    run_req(1'b1, 2'd0, 1'b0, 32'h701, 32'h0000_00A5, 32'h0, 2);

    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a[1:0] = a[1:0] & ~2'((1 << sz) - 1);
      nw = ($urandom_range(0, 7) == 0) ? TO + 2 : int'($urandom_range(0, 3));
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom, nw);
    end

    reset_mid_access();
    run_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
